// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: register-address width, forward-select codes
// and the per-stage destination entry tracked by the scoreboard.
package cpu_pkg;

    localparam int AW = 5;

    localparam logic [1:0] FWD_REG    = 2'd0;
    localparam logic [1:0] FWD_EXALU  = 2'd1;
    localparam logic [1:0] FWD_MEMALU = 2'd2;
    localparam logic [1:0] FWD_MEMLD  = 2'd3;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] dest;
        logic          wreg;
        logic          m2reg;
    } stage_t;

    // A stage only produces a register value if it writes a non-zero register.
    function automatic logic is_live(stage_t e);
        return e.valid && e.wreg && (e.dest != '0);
    endfunction

endpackage

// File: rtl/dest_scoreboard_fwd_select.sv
// Forward-select for one decode-stage source operand; the youngest live
// producer (EX before MEM) wins, and EX loads are never forwarded.
module fwd_select
    import cpu_pkg::*;
(
    input  logic [AW-1:0] src_i,
    input  logic          use_i,
    input  stage_t        ex_i,
    input  stage_t        mem_i,
    output logic [1:0]    sel_o
);

    always_comb begin
        sel_o = FWD_REG;
        if (use_i) begin
            if (is_live(ex_i) && (ex_i.dest == src_i) && !ex_i.m2reg) begin
                sel_o = FWD_EXALU;
            end else if (is_live(mem_i) && (mem_i.dest == src_i)) begin
                sel_o = mem_i.m2reg ? FWD_MEMLD : FWD_MEMALU;
            end
        end
    end

endmodule

// File: rtl/dest_scoreboard.sv
// Destination scoreboard for EX/MEM/WB: load-use stall, forwarding selects,
// register-file write port and a saturating stall-cycle counter.
module dest_scoreboard #(
    parameter int AW    = cpu_pkg::AW,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs,
    input  logic [AW-1:0]    id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [AW-1:0]    id_dest,
    input  logic             id_wreg,
    input  logic             id_m2reg,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             wb_we,
    output logic [AW-1:0]    wb_dest,
    output logic [CNT_W-1:0] stall_cnt
);

    import cpu_pkg::*;

    stage_t            ex_q, ex_d;
    stage_t            mem_q;
    stage_t            wb_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              load_use;

    always_comb begin
        load_use = id_valid && !flush && is_live(ex_q) && ex_q.m2reg &&
                   ((id_use_rs && (id_rs == ex_q.dest)) ||
                    (id_use_rt && (id_rt == ex_q.dest)));

        // Bubbles are fully cleared so a squashed instruction leaves no trace.
        ex_d = '0;
        if (id_valid && !load_use && !flush) begin
            ex_d.valid = 1'b1;
            ex_d.dest  = id_dest;
            ex_d.wreg  = id_wreg;
            ex_d.m2reg = id_m2reg;
        end

        cnt_d = cnt_q;
        if (load_use && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            cnt_q <= cnt_d;
        end
    end

    fwd_select u_fwd_rs (
        .src_i (id_rs),
        .use_i (id_valid && id_use_rs),
        .ex_i  (ex_q),
        .mem_i (mem_q),
        .sel_o (fwda)
    );

    fwd_select u_fwd_rt (
        .src_i (id_rt),
        .use_i (id_valid && id_use_rt),
        .ex_i  (ex_q),
        .mem_i (mem_q),
        .sel_o (fwdb)
    );

    assign stall     = load_use;
    assign wb_we     = is_live(wb_q);
    assign wb_dest   = wb_q.dest;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_dest_scoreboard.sv
// Directed bench for dest_scoreboard; expected register-file writes are queued
// when an instruction is offered and popped when it should reach WB.
module tb_dest_scoreboard;

    localparam int AW    = 5;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             clrn;
    logic             id_valid;
    logic [AW-1:0]    id_rs, id_rt, id_dest;
    logic             id_use_rs, id_use_rt, id_wreg, id_m2reg, flush;
    logic             stall, wb_we;
    logic [1:0]       fwda, fwdb;
    logic [AW-1:0]    wb_dest;
    logic [CNT_W-1:0] stall_cnt;

    typedef struct {
        logic          we;
        logic [AW-1:0] dest;
    } wb_exp_t;

    wb_exp_t wb_q[$];
    int      tests   = 0;
    int      fails   = 0;
    int      stepno  = 0;
    int      exp_cnt = 0;

    always #5 clk = ~clk;

    dest_scoreboard #(
        .AW    (AW),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .id_valid  (id_valid),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_rs (id_use_rs),
        .id_use_rt (id_use_rt),
        .id_dest   (id_dest),
        .id_wreg   (id_wreg),
        .id_m2reg  (id_m2reg),
        .flush     (flush),
        .stall     (stall),
        .fwda      (fwda),
        .fwdb      (fwdb),
        .wb_we     (wb_we),
        .wb_dest   (wb_dest),
        .stall_cnt (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL step%0d %s: got %0h expected %0h", stepno, tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        id_valid  = 1'b0;
        id_rs     = '0;
        id_rt     = '0;
        id_use_rs = 1'b0;
        id_use_rt = 1'b0;
        id_dest   = '0;
        id_wreg   = 1'b0;
        id_m2reg  = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic do_reset();
        wb_exp_t b;
        clrn = 1'b0;
        drive_idle();
        @(posedge clk);
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_fwda", fwda, 0);
        chk("rst_fwdb", fwdb, 0);
        chk("rst_wb_we", wb_we, 0);
        chk("rst_wb_dest", wb_dest, 0);
        chk("rst_cnt", stall_cnt, 0);
        clrn = 1'b1;
        exp_cnt = 0;
        wb_q.delete();
        b.we = 1'b0;
        b.dest = '0;
        repeat (3) wb_q.push_back(b);
    endtask

    task automatic step(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic urs, input logic urt, input logic [AW-1:0] dst,
                        input logic wr, input logic ld, input logic fl,
                        input logic es, input logic [1:0] efa, input logic [1:0] efb);
        wb_exp_t e, n;
        @(negedge clk);
        stepno++;
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_dest = dst; id_wreg = wr; id_m2reg = ld; flush = fl;
        #1;
        chk("stall", stall, es);
        chk("fwda", fwda, efa);
        chk("fwdb", fwdb, efb);
        chk("stall_cnt", stall_cnt, exp_cnt);
        if (wb_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL step%0d scoreboard: got empty queue expected entry", stepno);
        end else begin
            e = wb_q.pop_front();
            chk("wb_we", wb_we, e.we);
            if (e.we) chk("wb_dest", wb_dest, e.dest);
        end
        if (es && exp_cnt < (2**CNT_W - 1)) exp_cnt++;
        n.we   = v && !fl && !es && wr && (dst != 0);
        n.dest = dst;
        wb_q.push_back(n);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        idle();
        // ALU -> ALU chain on $3
        step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0);
        step(1, 3, 0, 1, 0, 4, 1, 0, 0, 0, 1, 0);
        step(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 2, 0);
        // load-use on $5
        step(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0);
        step(1, 0, 5, 0, 1, 6, 1, 0, 0, 1, 0, 0);
        step(1, 0, 5, 0, 1, 6, 1, 0, 0, 0, 0, 3);
        idle();
        idle();
        // register 0 never hazards or writes
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1, 8, 1, 0, 0, 0, 0, 0);
        // EX beats MEM for $7
        step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0);
        step(1, 7, 7, 1, 1, 0, 0, 0, 0, 0, 1, 1);
        // flush overrides load-use; flushed $10 must not reach EX
        step(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0);
        step(1, 9, 0, 1, 0, 10, 1, 0, 1, 0, 0, 0);
        step(1, 10, 9, 1, 1, 0, 0, 0, 0, 0, 0, 3);
        // id_valid=0 masks a load-use match
        step(1, 0, 0, 0, 0, 11, 1, 1, 0, 0, 0, 0);
        step(0, 11, 11, 1, 1, 12, 1, 0, 0, 0, 0, 0);
        // more load-use pairs drive the 2-bit counter into saturation
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 0, 0, 0, 12, 1, 1, 0, 0, 0, 0);
            step(1, 0, 12, 0, 1, 13, 1, 0, 0, 1, 0, 0);
            step(1, 0, 12, 0, 1, 13, 1, 0, 0, 0, 0, 3);
        end
        idle();
        idle();
        idle();
        // reset with three live writers in flight
        step(1, 0, 0, 0, 0, 13, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 14, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 15, 1, 0, 0, 0, 0, 0);
        do_reset();
        repeat (4) step(1, 13, 14, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        idle();
        idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
